// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button PRESS/LONG/REPEAT/RELEASE FSMs feeding
// one-deep pending slots, serialised by a round-robin arbiter onto a valid/ready port.
module btn_event_ctrl #(
    parameter int N          = 4,
    parameter int CNT_W      = 20,
    parameter int LONG_CYC   = 20,
    parameter int REPEAT_CYC = 8,
    localparam int ID_W      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    btn_in,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [1:0]      evt_code,
    output logic [N-1:0]    ovf,
    input  logic [N-1:0]    ovf_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD
    } state_t;

    localparam logic [1:0] C_RELEASE = 2'b00;
    localparam logic [1:0] C_PRESS   = 2'b01;
    localparam logic [1:0] C_LONG    = 2'b10;
    localparam logic [1:0] C_REPEAT  = 2'b11;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    state_t           state_q [N];
    state_t           state_d [N];
    logic [CNT_W-1:0] cnt_q   [N];
    logic [CNT_W-1:0] cnt_d   [N];

    logic [N-1:0]     prev_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic [N-1:0]     gen_v;
    logic [1:0]       gen_code [N];

    logic [N-1:0]     slot_v_q;
    logic [1:0]       slot_code_q [N];

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_next;
    logic             loadable;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    logic [N-1:0]     gnt_hit;

    assign rise = btn_in & ~prev_q;
    assign fall = ~btn_in & prev_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            gen_v[i]    = 1'b0;
            gen_code[i] = C_RELEASE;
            if (!en) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (rise[i]) begin
                            state_d[i]  = S_PRESSED;
                            cnt_d[i]    = '0;
                            gen_v[i]    = 1'b1;
                            gen_code[i] = C_PRESS;
                        end
                    end
                    S_PRESSED, S_HELD: begin
                        // A release wins over a LONG/REPEAT falling on the same cycle.
                        if (fall[i]) begin
                            state_d[i]  = S_IDLE;
                            cnt_d[i]    = '0;
                            gen_v[i]    = 1'b1;
                            gen_code[i] = C_RELEASE;
                        end else if (state_q[i] == S_PRESSED && cnt_q[i] == LONG_LAST) begin
                            state_d[i]  = S_HELD;
                            cnt_d[i]    = '0;
                            gen_v[i]    = 1'b1;
                            gen_code[i] = C_LONG;
                        end else if (state_q[i] == S_HELD && cnt_q[i] == REPEAT_LAST) begin
                            cnt_d[i]    = '0;
                            gen_v[i]    = 1'b1;
                            gen_code[i] = C_REPEAT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo N.
    always_comb begin
        loadable  = !evt_valid || evt_ready;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_found && slot_v_q[ID_W'((int'(ptr_q) + k) % N)]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(ptr_q) + k) % N);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt_hit[i] = loadable && gnt_found && (gnt_id == ID_W'(i));
        end
        ptr_next = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    // NOTE: the slot array is reset because a flushed event must never reappear after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            slot_v_q  <= '0;
            ovf       <= '0;
            ptr_q     <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_code  <= C_RELEASE;
            for (int i = 0; i < N; i++) begin
                slot_code_q[i] <= C_RELEASE;
            end
        end else begin
            prev_q <= btn_in;
            for (int i = 0; i < N; i++) begin
                // A slot granted this cycle is free again, so a same-cycle event still fits.
                if (gen_v[i] && (!slot_v_q[i] || gnt_hit[i])) begin
                    slot_v_q[i]    <= 1'b1;
                    slot_code_q[i] <= gen_code[i];
                end else if (gnt_hit[i]) begin
                    slot_v_q[i] <= 1'b0;
                end

                if (gen_v[i] && slot_v_q[i] && !gnt_hit[i]) begin
                    ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
            end

            if (loadable) begin
                evt_valid <= gnt_found;
                if (gnt_found) begin
                    evt_id   <= gnt_id;
                    evt_code <= slot_code_q[gnt_id];
                    ptr_q    <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: a timestamp-based event model checked every
// cycle, plus directed scenarios with hand-computed event sequences.
module tb_btn_event_ctrl;

    localparam int N          = 4;
    localparam int CNT_W      = 20;
    localparam int LONG_CYC   = 20;
    localparam int REPEAT_CYC = 8;
    localparam int ID_W       = $clog2(N);

    localparam int RELEASE = 0;
    localparam int PRESS   = 1;
    localparam int LONG    = 2;
    localparam int REPEAT  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    btn_in;
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [1:0]      evt_code;
    logic [N-1:0]    ovf;
    logic [N-1:0]    ovf_clr;

    btn_event_ctrl #(
        .N(N), .CNT_W(CNT_W), .LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .btn_in(btn_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_code(evt_code), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: events derived from how long each button has been held since its press edge.
    int   cyc = 0;
    bit   started = 0;
    bit   m_active [N];
    int   m_t0     [N];
    bit   m_prev   [N];
    bit   m_slot_v [N];
    int   m_slot_c [N];
    bit   m_ovf    [N];
    bit   m_valid;
    int   m_id, m_code, m_ptr;

    always @(posedge clk) begin
        bit ev_v [N];
        int ev_c [N];
        int gnt;
        bit set_now;
        bit load;
        cyc++;
        started = 1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_active[i] = 0; m_prev[i] = 0; m_slot_v[i] = 0; m_ovf[i] = 0; m_slot_c[i] = 0;
            end
            m_valid = 0; m_id = 0; m_code = 0; m_ptr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bit r, f;
                int el;
                r = btn_in[i] && !m_prev[i];
                f = !btn_in[i] && m_prev[i];
                ev_v[i] = 0; ev_c[i] = 0;
                if (!en) begin
                    m_active[i] = 0;
                end else if (!m_active[i]) begin
                    if (r) begin m_active[i] = 1; m_t0[i] = cyc; ev_v[i] = 1; ev_c[i] = PRESS; end
                end else if (f) begin
                    m_active[i] = 0; ev_v[i] = 1; ev_c[i] = RELEASE;
                end else begin
                    el = cyc - m_t0[i];
                    if (el == LONG_CYC) begin ev_v[i] = 1; ev_c[i] = LONG; end
                    else if (el > LONG_CYC && (el - LONG_CYC) % REPEAT_CYC == 0) begin
                        ev_v[i] = 1; ev_c[i] = REPEAT;
                    end
                end
            end
            load = !m_valid || evt_ready;
            gnt = -1;
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    if (gnt < 0 && m_slot_v[(m_ptr + k) % N]) gnt = (m_ptr + k) % N;
                end
                if (gnt >= 0) begin
                    m_valid = 1; m_id = gnt; m_code = m_slot_c[gnt];
                    m_slot_v[gnt] = 0; m_ptr = (gnt + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                set_now = 0;
                if (ev_v[i]) begin
                    if (m_slot_v[i]) begin m_ovf[i] = 1; set_now = 1; end
                    else begin m_slot_v[i] = 1; m_slot_c[i] = ev_c[i]; end
                end
                if (ovf_clr[i] && !set_now) m_ovf[i] = 0;
                m_prev[i] = btn_in[i];
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted events.
    typedef struct { int id; int code; int cyc; } acc_t;
    acc_t acc_q[$];

    always @(negedge clk) begin
        if (started) begin
            logic [N-1:0] mo;
            for (int i = 0; i < N; i++) mo[i] = m_ovf[i];
            check("cmp_valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) begin
                check("cmp_id", 32'(evt_id), 32'(m_id));
                check("cmp_code", 32'(evt_code), 32'(m_code));
            end
            check("cmp_ovf", 32'(ovf), 32'(mo));
            if (evt_valid === 1'b1 && evt_ready === 1'b1)
                acc_q.push_back('{id: int'(evt_id), code: int'(evt_code), cyc: cyc});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_acc(input string name, input int idx, input int id, input int code);
        if (idx < acc_q.size()) begin
            check({name, "_id"}, 32'(acc_q[idx].id), 32'(id));
            check({name, "_code"}, 32'(acc_q[idx].code), 32'(code));
        end else begin
            check({name, "_present"}, 32'(acc_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic expect_gap(input string name, input int idx, input int gap);
        if (idx < acc_q.size()) check(name, 32'(acc_q[idx].cyc - acc_q[idx-1].cyc), 32'(gap));
        else check({name, "_present"}, 32'(acc_q.size()), 32'(idx + 1));
    endtask

    int pair_a [6] = '{1, 1, 0, 0, 3, 3};
    int pair_b [6] = '{3, 3, 2, 2, 0, 0};

    initial begin
        rst = 1; en = 1; btn_in = '0; evt_ready = 1; ovf_clr = '0;
        tick(2);
        rst = 0;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id", 32'(evt_id), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_ovf", 32'(ovf), 0);
        tick(2);

        // Short press on button 2: PRESS then RELEASE, no LONG.
        acc_q.delete();
        btn_in[2] = 1; tick(10); btn_in[2] = 0; tick(4);
        check("t1_count", 32'(acc_q.size()), 2);
        expect_acc("t1_e0", 0, 2, PRESS);
        expect_acc("t1_e1", 1, 2, RELEASE);
        check("t1_ovf", 32'(ovf), 0);

        // 40-cycle hold on button 0: PRESS, LONG +20, REPEAT +8, REPEAT +8, RELEASE +4.
        acc_q.delete();
        btn_in[0] = 1; tick(40); btn_in[0] = 0; tick(4);
        check("t2_count", 32'(acc_q.size()), 5);
        expect_acc("t2_e0", 0, 0, PRESS);
        expect_acc("t2_e1", 1, 0, LONG);
        expect_acc("t2_e2", 2, 0, REPEAT);
        expect_acc("t2_e3", 3, 0, REPEAT);
        expect_acc("t2_e4", 4, 0, RELEASE);
        expect_gap("t2_gap_long", 1, LONG_CYC);
        expect_gap("t2_gap_rep1", 2, REPEAT_CYC);
        expect_gap("t2_gap_rep2", 3, REPEAT_CYC);
        expect_gap("t2_gap_rel", 4, 4);

        // Simultaneous pairs: round-robin order including wrap-around.
        acc_q.delete();
        for (int p = 0; p < 6; p++) begin
            btn_in[pair_a[p]] = (p % 2 == 0);
            btn_in[pair_b[p]] = (p % 2 == 0);
            tick(4);
        end
        check("t3_count", 32'(acc_q.size()), 12);
        for (int p = 0; p < 6; p++) begin
            expect_acc($sformatf("t3_p%0d_first", p), 2*p, pair_a[p], (p % 2 == 0) ? PRESS : RELEASE);
            expect_acc($sformatf("t3_p%0d_second", p), 2*p+1, pair_b[p], (p % 2 == 0) ? PRESS : RELEASE);
            expect_gap($sformatf("t3_p%0d_gap", p), 2*p+1, 1);
        end

        // Backpressure: output holds PRESS, RELEASE waits in its slot.
        acc_q.delete();
        evt_ready = 0;
        btn_in[0] = 1; tick(3); btn_in[0] = 0; tick(3);
        check("t4_hold_valid", 32'(evt_valid), 1);
        check("t4_hold_id", 32'(evt_id), 0);
        check("t4_hold_code", 32'(evt_code), PRESS);
        check("t4_ovf", 32'(ovf), 0);
        evt_ready = 1; tick(3);
        check("t4_count", 32'(acc_q.size()), 2);
        expect_acc("t4_e0", 0, 0, PRESS);
        expect_acc("t4_e1", 1, 0, RELEASE);
        expect_gap("t4_gap", 1, 1);

        // Overflow: second PRESS dropped while the slot holds RELEASE; then cleared.
        acc_q.delete();
        evt_ready = 0;
        btn_in[0] = 1; tick(2); btn_in[0] = 0; tick(2);
        check("t5_ovf_before", 32'(ovf), 0);
        btn_in[0] = 1; tick(2);
        check("t5_ovf_set", 32'(ovf), 1);
        btn_in[0] = 0; tick(2);
        ovf_clr[0] = 1; tick(1); ovf_clr[0] = 0;
        check("t5_ovf_clr", 32'(ovf), 0);
        evt_ready = 1; tick(4);
        check("t5_count", 32'(acc_q.size()), 2);
        expect_acc("t5_e0", 0, 0, PRESS);
        expect_acc("t5_e1", 1, 0, RELEASE);

        // Enable gating: no events while disabled or for a button held across enable.
        acc_q.delete();
        en = 0; btn_in[1] = 1; tick(3);
        en = 1; tick(3); btn_in[1] = 0; tick(3);
        check("t7_none", 32'(acc_q.size()), 0);
        evt_ready = 0; btn_in[1] = 1; tick(2); btn_in[1] = 0; tick(2);
        en = 0; evt_ready = 1; tick(3);
        check("t7_drain", 32'(acc_q.size()), 2);
        expect_acc("t7_e1", 1, 1, RELEASE);
        en = 1; tick(2);

        // Reset mid-operation with button 2 held: flush, then PRESS right after reset.
        evt_ready = 0;
        btn_in[2] = 1; tick(3);
        check("t6_pre_valid", 32'(evt_valid), 1);
        rst = 1; tick(1); rst = 0;
        check("t6_rst_valid", 32'(evt_valid), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        tick(1);
        check("t6_latency", 32'(evt_valid), 0);
        tick(1);
        check("t6_press_valid", 32'(evt_valid), 1);
        check("t6_press_id", 32'(evt_id), 2);
        check("t6_press_code", 32'(evt_code), PRESS);
        btn_in[2] = 0; evt_ready = 1; tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
